// File: rtl/pool_window_scheduler.sv
// Sequences a 3x3 max-pool over one square channel: serial window fetch, pool issue, latency wait, result write.
// Optional define POOL_SCHED_PERF_EN adds perf_cycles / perf_stall counters.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef POOL_SIZE
`define POOL_SIZE (9*`DATA_WIDTH)
`endif

module pool_window_scheduler #(
  parameter int FM_SIZE    = 55,
  parameter int POOL_K     = 3,
  parameter int STRIDE     = 2,
  parameter int OUT_SIZE   = (FM_SIZE - POOL_K) / STRIDE + 1,
  parameter int ADDR_WIDTH = 12,
  parameter int POOL_LAT   = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   fm_base,
  input  logic [ADDR_WIDTH-1:0]   out_base,
  output logic                    rd_req,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic                    rd_valid,
  input  logic [`DATA_WIDTH-1:0]  rd_data,
  output logic                    pool_ena,
  output logic [`POOL_SIZE-1:0]   pool_vector,
  input  logic [`DATA_WIDTH-1:0]  pool_result,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [`DATA_WIDTH-1:0]  wr_data,
  input  logic                    wr_ready,
  output logic                    busy,
  output logic                    done
`ifdef POOL_SCHED_PERF_EN
  ,
  output logic [31:0]             perf_cycles,
  output logic [31:0]             perf_stall
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int K_LAST = POOL_K * POOL_K - 1;
  localparam int LAT_W  = $clog2(POOL_LAT + 1);
  localparam logic [ADDR_WIDTH-1:0] A_FM     = ADDR_WIDTH'(FM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] A_STRIDE = ADDR_WIDTH'(STRIDE);
  localparam logic [ADDR_WIDTH-1:0] A_OUT    = ADDR_WIDTH'(OUT_SIZE);
  localparam logic [ADDR_WIDTH-1:0] A_LAST   = ADDR_WIDTH'(OUT_SIZE - 1);

  logic [2:0]              r_state;
  logic [ADDR_WIDTH-1:0]   r_fmBase;
  logic [ADDR_WIDTH-1:0]   r_outBase;
  logic [ADDR_WIDTH-1:0]   r_ox;
  logic [ADDR_WIDTH-1:0]   r_oy;
  logic [3:0]              r_k;
  logic [1:0]              r_kRow;
  logic [1:0]              r_kCol;
  logic [LAT_W-1:0]        r_latCnt;
  logic [`POOL_SIZE-1:0]   r_vec;
  logic [`DATA_WIDTH-1:0]  r_wrData;

  logic [ADDR_WIDTH-1:0]   w_rowOff;
  logic [ADDR_WIDTH-1:0]   w_rdAddr;
  logic [ADDR_WIDTH-1:0]   w_wrAddr;
  logic                    w_lastPos;

  // Window row/column within the 3x3 are tracked directly, avoiding a divide-by-3 of k.
  assign w_rowOff  = r_oy * A_STRIDE + {{(ADDR_WIDTH-2){1'b0}}, r_kRow};
  assign w_rdAddr  = r_fmBase + w_rowOff * A_FM + r_ox * A_STRIDE + {{(ADDR_WIDTH-2){1'b0}}, r_kCol};
  assign w_wrAddr  = r_outBase + r_oy * A_OUT + r_ox;
  assign w_lastPos = (r_ox == A_LAST) && (r_oy == A_LAST);

  assign rd_req      = (r_state == S_FETCH);
  assign rd_addr     = rd_req ? w_rdAddr : '0;
  assign pool_ena    = (r_state == S_ISSUE);
  assign pool_vector = r_vec;
  assign wr_en       = (r_state == S_WRITE);
  assign wr_addr     = wr_en ? w_wrAddr : '0;
  assign wr_data     = r_wrData;
  assign busy        = (r_state == S_FETCH) || (r_state == S_ISSUE) ||
                       (r_state == S_WAIT)  || (r_state == S_WRITE);
  assign done        = (r_state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_fmBase  <= '0;
      r_outBase <= '0;
      r_ox      <= '0;
      r_oy      <= '0;
      r_k       <= '0;
      r_kRow    <= '0;
      r_kCol    <= '0;
      r_latCnt  <= '0;
      r_vec     <= '0;
      r_wrData  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_fmBase  <= fm_base;
            r_outBase <= out_base;
            r_ox      <= '0;
            r_oy      <= '0;
            r_k       <= '0;
            r_kRow    <= '0;
            r_kCol    <= '0;
            r_state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (rd_valid) begin
            for (int i = 0; i <= K_LAST; i++) begin
              if (r_k == 4'(i)) r_vec[i*`DATA_WIDTH +: `DATA_WIDTH] <= rd_data;
            end
            if (r_k == 4'(K_LAST)) begin
              r_k     <= '0;
              r_kRow  <= '0;
              r_kCol  <= '0;
              r_state <= S_ISSUE;
            end else begin
              r_k <= r_k + 4'd1;
              if (r_kCol == 2'(POOL_K - 1)) begin
                r_kCol <= '0;
                r_kRow <= r_kRow + 2'd1;
              end else begin
                r_kCol <= r_kCol + 2'd1;
              end
            end
          end
        end
        S_ISSUE: begin
          r_latCnt <= '0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (r_latCnt == LAT_W'(POOL_LAT - 1)) begin
            r_wrData <= pool_result;
            r_state  <= S_WRITE;
          end else begin
            r_latCnt <= r_latCnt + 1'b1;
          end
        end
        S_WRITE: begin
          if (wr_ready) begin
            if (w_lastPos) begin
              r_state <= S_DONE;
            end else begin
              if (r_ox == A_LAST) begin
                r_ox <= '0;
                r_oy <= r_oy + 1'b1;
              end else begin
                r_ox <= r_ox + 1'b1;
              end
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef POOL_SCHED_PERF_EN
  logic [31:0] r_perfCycles;
  logic [31:0] r_perfStall;

  // Both counters saturate and are cleared only by reset or an accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perfCycles <= '0;
      r_perfStall  <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_perfCycles <= '0;
      r_perfStall  <= '0;
    end else begin
      if (busy && (r_perfCycles != 32'hFFFF_FFFF)) r_perfCycles <= r_perfCycles + 32'd1;
      if ((((r_state == S_FETCH) && !rd_valid) || ((r_state == S_WRITE) && !wr_ready)) &&
          (r_perfStall != 32'hFFFF_FFFF))
        r_perfStall <= r_perfStall + 32'd1;
    end
  end

  assign perf_cycles = r_perfCycles;
  assign perf_stall  = r_perfStall;
`endif

endmodule

// File: tb/tb_pool_window_scheduler.sv
// Testbench for pool_window_scheduler on a 5x5 map: acts as FM buffer (mem[a]=fp32(a)), max_pool and output buffer.
module tb_pool_window_scheduler;
  localparam int FM = 5;
  localparam int OUTS = 2;
  localparam int STR = 2;
  localparam int AW = 12;
  localparam int LAT = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [AW-1:0] fm_base = '0;
  logic [AW-1:0] out_base = '0;
  logic rd_req;
  logic [AW-1:0] rd_addr;
  logic rd_valid = 1'b0;
  logic [31:0] rd_data = '0;
  logic pool_ena;
  logic [287:0] pool_vector;
  logic [31:0] pool_result = '0;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0] wr_data;
  logic wr_ready = 1'b0;
  logic busy;
  logic done;
`ifdef POOL_SCHED_PERF_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_stall;
`endif

  pool_window_scheduler #(.FM_SIZE(FM), .STRIDE(STR), .ADDR_WIDTH(AW), .POOL_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .fm_base(fm_base), .out_base(out_base),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .pool_ena(pool_ena), .pool_vector(pool_vector), .pool_result(pool_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done)
`ifdef POOL_SCHED_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int validPct = 100;
  int readyPct = 100;
  int stallLeft = 0;
  int busyCnt = 0;
  int doneCnt = 0;
  int poolEnaCnt = 0;
  int firstWrCycles = 0;
  int poolCnt = -1;
  logic [31:0] poolVal = '0;
  logic prevEna = 1'b0;
  logic rdPend = 1'b0;
  logic [AW-1:0] rdPendAddr = '0;
  logic wrPend = 1'b0;
  logic [AW-1:0] wrPendAddr = '0;
  logic [31:0] wrPendData = '0;
  logic [AW-1:0] rdLog[$];
  logic [AW-1:0] wrAddrLog[$];
  logic [31:0] wrDataLog[$];

  typedef struct {
    logic [AW-1:0] fmB;
    logic [AW-1:0] outB;
    int vPct;
    int rPct;
    int stall;
    int expBusy;
  } vec_t;

  vec_t tbl[5];

  task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fp32(input int a);
    int e;
    logic [31:0] m;
    if (a == 0) return 32'd0;
    e = 0;
    for (int i = 0; i < 24; i++) if (a[i]) e = i;
    m = 32'(a) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  // Environment: FM buffer, max_pool with fixed latency, output buffer, plus protocol checks.
  always @(negedge clk) begin
    if (!reset) begin
      rd_valid = 1'b0;
      rd_data = '0;
      wr_ready = 1'b0;
      pool_result = '0;
      poolCnt = -1;
      rdPend = 1'b0;
      wrPend = 1'b0;
      prevEna = 1'b0;
    end else begin
      if (rd_req && rdPend) checkEq("rd_addr_hold", rd_addr, rdPendAddr);
      rd_valid = rd_req && ($urandom_range(99) < validPct);
      rd_data = rd_valid ? fp32(int'(rd_addr)) : $urandom;
      if (rd_valid) rdLog.push_back(rd_addr);
      rdPend = rd_req && !rd_valid;
      rdPendAddr = rd_addr;

      if (pool_ena) begin
        checkEq("pool_ena_single", prevEna, 0);
        poolEnaCnt++;
        poolVal = '0;
        for (int i = 0; i < 9; i++) begin
          if (rdLog.size() >= 9)
            checkEq("pool_vector_elem", pool_vector[i*32 +: 32], fp32(int'(rdLog[rdLog.size()-9+i])));
          if (pool_vector[i*32 +: 32] > poolVal) poolVal = pool_vector[i*32 +: 32];
        end
        poolCnt = LAT;
      end else if (poolCnt >= 0) begin
        poolCnt--;
      end
      prevEna = pool_ena;
      pool_result = (poolCnt == 0) ? poolVal : $urandom;

      if (wrPend) begin
        checkEq("wr_en_hold", wr_en, 1);
        checkEq("wr_addr_hold", wr_addr, wrPendAddr);
        checkEq("wr_data_hold", wr_data, wrPendData);
        checkEq("no_rd_req_while_write", rd_req, 0);
      end
      if (wr_en && wrAddrLog.size() == 0) firstWrCycles++;
      if (wr_en && wrAddrLog.size() == 0 && stallLeft > 0) begin
        wr_ready = 1'b0;
        stallLeft--;
      end else begin
        wr_ready = ($urandom_range(99) < readyPct);
      end
      if (wr_en && wr_ready) begin
        wrAddrLog.push_back(wr_addr);
        wrDataLog.push_back(wr_data);
      end
      wrPend = wr_en && !wr_ready;
      wrPendAddr = wr_addr;
      wrPendData = wr_data;

      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        checkEq("busy_low_at_done", busy, 0);
      end
    end
  end

  task automatic checkResetOutputs();
    checkEq("rst_rd_req", rd_req, 0);
    checkEq("rst_rd_addr", rd_addr, 0);
    checkEq("rst_pool_ena", pool_ena, 0);
    checkEq("rst_pool_vector_zero", (pool_vector == '0), 1);
    checkEq("rst_wr_en", wr_en, 0);
    checkEq("rst_wr_addr", wr_addr, 0);
    checkEq("rst_wr_data", wr_data, 0);
    checkEq("rst_busy", busy, 0);
    checkEq("rst_done", done, 0);
  endtask

  // Runs one channel; extraStartAt>0 pulses start again mid-run with bogus bases.
  task automatic applyStimulus(input vec_t v, input int extraStartAt);
    int cyc;
    int d0;
    validPct = v.vPct;
    readyPct = v.rPct;
    stallLeft = v.stall;
    rdLog.delete();
    wrAddrLog.delete();
    wrDataLog.delete();
    firstWrCycles = 0;
    busyCnt = 0;
    d0 = doneCnt;
    @(negedge clk); #1;
    fm_base = v.fmB;
    out_base = v.outB;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (doneCnt == d0 && cyc < 3000) begin
      @(negedge clk); #1;
      cyc++;
      if (cyc == extraStartAt) begin
        start = 1'b1;
        fm_base = 12'd999;
        out_base = 12'd555;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checkEq("done_within_budget", (doneCnt - d0), 1);
  endtask

  // Reference: each output position's window addresses and the max of their fp32 values.
  task automatic checkOutput(input vec_t v);
    int idx;
    int a;
    logic [31:0] mx;
    checkEq("read_count", rdLog.size(), 36);
    checkEq("write_count", wrAddrLog.size(), 4);
    idx = 0;
    for (int oy = 0; oy < OUTS; oy++) begin
      for (int ox = 0; ox < OUTS; ox++) begin
        mx = '0;
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            a = (int'(v.fmB) + (oy*STR + r)*FM + ox*STR + c) % 4096;
            if (fp32(a) > mx) mx = fp32(a);
            if (rdLog.size() > idx*9 + r*3 + c)
              checkEq("rd_addr_seq", rdLog[idx*9 + r*3 + c], a);
          end
        end
        if (wrAddrLog.size() > idx) begin
          checkEq("wr_addr", wrAddrLog[idx], (int'(v.outB) + oy*OUTS + ox) % 4096);
          checkEq("wr_data", wrDataLog[idx], mx);
        end
        idx++;
      end
    end
    if (v.expBusy >= 0) checkEq("busy_cycles", busyCnt, v.expBusy);
    if (v.stall > 0) checkEq("first_write_held_cycles", firstWrCycles, v.stall + 1);
`ifdef POOL_SCHED_PERF_EN
    if (v.expBusy >= 0) checkEq("perf_cycles", perf_cycles, v.expBusy);
    if (v.vPct == 100 && v.rPct == 100) checkEq("perf_stall", perf_stall, v.stall);
`endif
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [AW-1:0] win11[9];
    int base;
    int d0;
    int cyc;
    win11 = '{12'd12, 12'd13, 12'd14, 12'd17, 12'd18, 12'd19, 12'd22, 12'd23, 12'd24};

    tbl[0] = '{12'd0,    12'd100,  100, 100, 0, 64};
    tbl[1] = '{12'd0,    12'd100,  50,  100, 0, -1};
    tbl[2] = '{12'd0,    12'd100,  100, 100, 7, 71};
    tbl[3] = '{12'd37,   12'd4094, 70,  60,  0, -1};
    tbl[4] = '{12'd4090, 12'd200,  100, 100, 0, 64};

    repeat (3) @(negedge clk);
    #1 checkResetOutputs();
    reset = 1'b1;

    for (int r = 0; r < 5; r++) begin
      applyStimulus(tbl[r], 0);
      checkOutput(tbl[r]);
      if (r == 0 && rdLog.size() == 36) begin
        for (int i = 0; i < 9; i++) checkEq("window11_rd_addr", rdLog[27 + i], win11[i]);
      end
    end

    applyStimulus(tbl[0], 10);
    checkOutput(tbl[0]);

    // Abort during the WAIT of the second window; no done and only one write may appear.
    validPct = 100;
    readyPct = 100;
    stallLeft = 0;
    rdLog.delete();
    wrAddrLog.delete();
    wrDataLog.delete();
    base = poolEnaCnt;
    d0 = doneCnt;
    @(negedge clk); #1;
    fm_base = '0;
    out_base = 12'd100;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (poolEnaCnt < base + 2 && cyc < 500) begin
      @(negedge clk); #1;
      cyc++;
    end
    checkEq("reached_window2_issue", (poolEnaCnt >= base + 2), 1);
    @(negedge clk); #1;
    reset = 1'b0;
    #1 checkResetOutputs();
    repeat (3) @(negedge clk);
    #1 checkResetOutputs();
    checkEq("no_done_on_abort", doneCnt, d0);
    checkEq("writes_before_abort", wrAddrLog.size(), 1);
    reset = 1'b1;

    applyStimulus(tbl[0], 0);
    checkOutput(tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
